// File: rtl/demon_baby_pkg.sv
// Shared types and constants for the demon-baby tile: arbiter state encoding,
// output bus width and the blank payload shown when no requester owns uo_out.
package demon_baby_pkg;
  localparam int IO_WIDTH = 8;
  localparam logic [IO_WIDTH-1:0] BLANK = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;
endpackage

// File: rtl/demon_baby_prescaler.sv
// Free-running divider: emits a registered one-cycle tick after every MAX_COUNT
// clocks. Held cleared while ena is low. Also used by the pet timers.
module demon_baby_prescaler #(
  parameter int MAX_COUNT = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);
  localparam int CW = $clog2(MAX_COUNT);
  localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (!ena) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == LAST);
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/demon_baby_io_arbiter.sv
// Round-robin time-slice arbiter for the tile's 8-bit output bus. Each grant
// lasts SLOT_TICKS prescaler ticks. Define DEMON_BABY_GAP_EN to blank until the next tick after each release.
module demon_baby_io_arbiter
  import demon_baby_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MAX_COUNT  = 10_000_000,
  parameter int SLOT_TICKS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [IO_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [IO_WIDTH-1:0]         out_data,
  output logic                        out_valid,
  output logic                        tick
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(SLOT_TICKS + 1);

  arb_state_e                        state_q;
  logic [PW-1:0]                     ptr_q, win_q, win_d, ptr_d;
  logic [SW-1:0]                     slot_q, slot_d;
  logic [NUM_REQ-1:0]                grant_q;
  logic [IO_WIDTH-1:0]               data_q;
  logic                              valid_q;
  logic                              release_d;
  logic [NUM_REQ-1:0][IO_WIDTH-1:0]  req_data_v;

  assign req_data_v = req_data;

  demon_baby_prescaler #(.MAX_COUNT(MAX_COUNT)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick)
  );

  // Rotating priority: descending scan so the lowest offset from ptr wins.
  always_comb begin
    win_d = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr_q) + off) % NUM_REQ])
        win_d = PW'((int'(ptr_q) + off) % NUM_REQ);
    end
  end

  always_comb begin
    slot_d    = slot_q + SW'(1);
    ptr_d     = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);
    release_d = !req[win_q] || (tick && (slot_d == SW'(SLOT_TICKS)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      slot_q  <= '0;
      grant_q <= '0;
      data_q  <= BLANK;
      valid_q <= 1'b0;
    end else if (!ena) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      slot_q  <= '0;
      grant_q <= '0;
      data_q  <= BLANK;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          slot_q <= '0;
          data_q <= BLANK;
          if (|req) begin
            state_q <= ST_GRANT;
            win_q   <= win_d;
            grant_q <= NUM_REQ'(1) << win_d;
            valid_q <= 1'b1;
          end else begin
            grant_q <= '0;
            valid_q <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (release_d) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            data_q  <= BLANK;
            ptr_q   <= ptr_d;
`ifdef DEMON_BABY_GAP_EN
            state_q <= ST_GAP;
`else
            state_q <= ST_IDLE;
`endif
          end else begin
            data_q <= req_data_v[win_q];
            if (tick) slot_q <= slot_d;
          end
        end
`ifdef DEMON_BABY_GAP_EN
        ST_GAP: begin
          if (tick) state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_demon_baby_io_arbiter.sv
// Randomized bench for demon_baby_io_arbiter against a cycle-level behavioural
// model of the slot/round-robin rules, plus directed ordering and reset checks.
module tb_demon_baby_io_arbiter;
  localparam int N  = 4;
  localparam int MC = 4;
  localparam int ST = 2;
`ifdef DEMON_BABY_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam logic [8*N-1:0] PAY = 32'h4332_2110;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   grant;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           tick;

  demon_baby_io_arbiter #(.NUM_REQ(N), .MAX_COUNT(MC), .SLOT_TICKS(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .out_data  (out_data),
    .out_valid (out_valid),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: owner (-1 = none), ticks seen in slot, pointer, edges since clear
  int         m_owner, m_ptr, m_ticks, m_cyc;
  bit         m_gap;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return (m_cyc > 0) && (m_cyc % MC == 0);
  endfunction

  task automatic m_clear();
    m_owner = -1; m_ptr = 0; m_ticks = 0; m_cyc = 0; m_gap = 1'b0; m_data = 8'h00;
  endtask

  task automatic m_edge(input bit e, input logic [N-1:0] r, input logic [8*N-1:0] d);
    bit t;
    t = m_tick();
    if (!e) begin
      m_clear();
      return;
    end
    if (m_owner >= 0) begin
      if (!r[m_owner] || (t && m_ticks + 1 == ST)) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_data = 8'h00; m_gap = GAP_EN;
      end else begin
        m_data = d[m_owner*8 +: 8];
        if (t) m_ticks++;
      end
    end else if (m_gap) begin
      if (t) m_gap = 1'b0;
    end else if (r != '0) begin
      for (int k = 0; k < N; k++)
        if (r[(m_ptr + k) % N]) begin m_owner = (m_ptr + k) % N; break; end
      m_ticks = 0; m_data = 8'h00;
    end
    m_cyc++;
  endtask

  task automatic cmp_out(input string ph);
    chk({ph, ".grant"}, 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk({ph, ".valid"}, 32'(out_valid), 32'(m_owner >= 0));
    chk({ph, ".data"}, 32'(out_data), 32'(m_data));
    chk({ph, ".tick"}, 32'(tick), 32'(m_tick()));
  endtask

  task automatic cyc(input string ph, input bit e, input logic [N-1:0] r, input logic [8*N-1:0] d);
    ena = e; req = r; req_data = d;
    m_edge(e, r, d);
    @(negedge clk);
    cmp_out(ph);
  endtask

  initial begin
    logic [N-1:0]   r, prev;
    logic [8*N-1:0] d;
    int             order[$];
    int             exp_order[5];
    bit             found, first_seen;

    exp_order = '{0, 1, 2, 3, 0};
    m_clear();
    #3;
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) cyc("idle", 1'b1, '0, $urandom);
    for (int i = 0; i < 30; i++) cyc("single", 1'b1, 4'b0010, 32'h0000_A500);

    // fresh pointer, then all requesters: expect order 0,1,2,3,0
    cyc("clr", 1'b0, 4'hF, PAY);
    prev = '0;
    for (int i = 0; i < 64; i++) begin
      cyc("all", 1'b1, 4'hF, PAY);
      if (grant != '0 && prev == '0)
        for (int b = 0; b < N; b++) if (grant[b]) order.push_back(b);
      prev = grant;
    end
    chk("order.count", 32'(order.size() >= 5), 32'd1);
    if (order.size() >= 5)
      for (int k = 0; k < 5; k++) chk($sformatf("order[%0d]", k), 32'(order[k]), 32'(exp_order[k]));

    // early drop of requester 2: requester 3 must be next
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc("seek2", 1'b1, 4'hF, PAY);
      found = (grant == 4'b0100);
    end
    chk("seek2.found", 32'(found), 32'd1);
    cyc("drop", 1'b1, 4'b1011, PAY);
    chk("drop.release", 32'(grant), 32'd0);
    cyc("drop", 1'b1, 4'b1011, PAY);
    chk("drop.next", 32'(grant), 32'b1000);

    r = 4'hF;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(7) == 0) r = N'($urandom);
      d = $urandom;
      cyc("rnd", ($urandom_range(63) != 0), r, d);
    end

    // asynchronous reset in the middle of a grant
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc("pre", 1'b1, 4'hF, PAY);
      found = (m_owner >= 0) && (m_data != 8'h00);
    end
    chk("pre.valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.grant", 32'(grant), 32'd0);
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.data", 32'(out_data), 32'd0);
    chk("arst.tick", 32'(tick), 32'd0);
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    first_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc("post", 1'b1, 4'hF, PAY);
      if (!first_seen && grant != '0) begin
        first_seen = 1'b1;
        chk("post.first", 32'(grant), 32'b0001);
      end
    end
    chk("post.seen", 32'(first_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
